pe_result_collector: RTL and testbench

//  Downstream stage of the PE: captures the rounded 16-bit results (data_out / rounder_valid).

---
 rtl/pe_result_collector.sv | 185 ++++++++++++++++++
 tb/tb_pe_result_collector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// ============================================================================
// Module      : pe_result_collector
// Description : Packs PACK consecutive PE results into one word, queues the
//               words in a show-ahead FIFO and streams them out on valid/ready.
//               Drives stall back to the PE keep input so that results already
//               in flight cannot overflow the FIFO.
//               Optional statistics counters: define PE_COLLECT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_result_collector #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int PACK           = 4,
  parameter int DEPTH          = 8,
  parameter int AF_MARGIN      = 3
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [para_int_bits+para_frac_bits-1:0]       res_data_i,
  input  logic                                          res_valid_i,
  input  logic                                          flush_i,
  output logic                                          stall_o,
  output logic [PACK*(para_int_bits+para_frac_bits)-1:0] m_data_o,
  output logic [PACK-1:0]                               m_mask_o,
  output logic                                          m_valid_o,
  input  logic                                          m_ready_i,
  output logic                                          overflow_o
`ifdef PE_COLLECT_STATS_EN
  ,
  output logic [15:0]                                   word_cnt_o,
  output logic [7:0]                                    drop_cnt_o
`endif
);

  localparam int DATA_W = para_int_bits + para_frac_bits;
  localparam int WORD_W = PACK * DATA_W;
  localparam int LW     = $clog2(PACK);
  localparam int PW     = $clog2(DEPTH);

  localparam logic [LW-1:0] c_LAST_LANE = LW'(PACK - 1);
  localparam logic [PW:0]   c_FULL      = (PW+1)'(DEPTH);
  localparam logic [PW:0]   c_STALL_TH  = (PW+1)'(DEPTH - AF_MARGIN);

  // --------------------------------------------------------------------------
  // Pack stage
  // --------------------------------------------------------------------------
  logic [LW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;

  logic [WORD_W-1:0] buf_wr;
  logic [LW:0]       lane_fill;
  logic              word_done;
  logic              push;
  logic [PACK-1:0]   push_mask;
  logic [WORD_W-1:0] push_data;

  always_comb begin
    buf_wr = buf_q;
    if (res_valid_i) begin
      buf_wr[int'(lane_cnt_q)*DATA_W +: DATA_W] = res_data_i;
    end

    // lane_fill counts lanes occupied once this cycle's result is included
    lane_fill = {1'b0, lane_cnt_q} + (LW+1)'(res_valid_i);
    word_done = res_valid_i && (lane_cnt_q == c_LAST_LANE);
    push      = word_done || (flush_i && (lane_fill != '0));

    push_mask = '0;
    push_data = '0;
    for (int i = 0; i < PACK; i++) begin
      push_mask[i] = ((LW+1)'(i) < lane_fill);
      if (push_mask[i]) begin
        push_data[i*DATA_W +: DATA_W] = buf_wr[i*DATA_W +: DATA_W];
      end
    end

    if (push) begin
      buf_d      = '0;
      lane_cnt_d = '0;
    end else begin
      buf_d      = buf_wr;
      lane_cnt_d = lane_fill[LW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      buf_q      <= buf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Word FIFO
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] data_mem_q [DEPTH];
  logic [PACK-1:0]   mask_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          stall_q,  stall_d;
  logic          overflow_q, overflow_d;

  logic pop;
  logic accept;
  logic drop;

  always_comb begin
    pop    = (count_q != '0) && m_ready_i;
    // A full FIFO still takes a word when the head leaves in the same cycle
    accept = push && ((count_q != c_FULL) || pop);
    drop   = push && !accept;

    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    stall_d    = (count_d >= c_STALL_TH);
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; outputs are gated by m_valid so stale entries never show
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem_q[wr_ptr_q] <= push_data;
      mask_mem_q[wr_ptr_q] <= push_mask;
    end
  end

  assign m_valid_o  = (count_q != '0);
  assign m_data_o   = m_valid_o ? data_mem_q[rd_ptr_q] : '0;
  assign m_mask_o   = m_valid_o ? mask_mem_q[rd_ptr_q] : '0;
  assign stall_o    = stall_q;
  assign overflow_o = overflow_q;

`ifdef PE_COLLECT_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: popped words wrap, dropped words saturate
  // --------------------------------------------------------------------------
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    word_cnt_d = pop ? word_cnt_q + 16'd1 : word_cnt_q;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_result_collector.sv
// ============================================================================
// Module      : tb_pe_result_collector
// Description : Directed self-checking bench for pe_result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] res_data;
  logic        res_valid;
  logic        flush;
  logic        stall;
  logic [63:0] m_data;
  logic [3:0]  m_mask;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;
`ifdef PE_COLLECT_STATS_EN
  logic [15:0] word_cnt;
  logic [7:0]  drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_result_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_data_i  (res_data),
    .res_valid_i (res_valid),
    .flush_i     (flush),
    .stall_o     (stall),
    .m_data_o    (m_data),
    .m_mask_o    (m_mask),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .overflow_o  (overflow)
`ifdef PE_COLLECT_STATS_EN
    ,
    .word_cnt_o  (word_cnt),
    .drop_cnt_o  (drop_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        mv;
    logic [63:0] md;
    logic [3:0]  mk;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mkv(input logic v, input logic [15:0] d, input logic f,
                               input logic mv, input logic [63:0] md, input logic [3:0] mk);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.mv = mv; r.md = md; r.mk = mk;
    return r;
  endfunction

  // Word k carries lane i = {k, i}
  function automatic logic [63:0] wordk(input int k);
    logic [63:0] w;
    logic [7:0]  kb;
    kb = k[7:0];
    w  = '0;
    for (int i = 0; i < 4; i++) w[i*16 +: 16] = {kb, 8'(i)};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int k, input logic ready_last);
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_data  = {k[7:0], 8'(i)};
      m_ready   = (i == 3) ? ready_last : 1'b0;
      step();
    end
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  initial begin
    tbl[0]  = mkv(1'b1, 16'h0001, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[1]  = mkv(1'b1, 16'h0002, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[2]  = mkv(1'b1, 16'h0003, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[3]  = mkv(1'b1, 16'h0004, 1'b0, 1'b1, 64'h0004_0003_0002_0001, 4'hF);
    tbl[4]  = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[5]  = mkv(1'b1, 16'hAAAA, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[6]  = mkv(1'b1, 16'hBBBB, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[7]  = mkv(1'b0, 16'h0000, 1'b1, 1'b1, 64'h0000_0000_BBBB_AAAA, 4'h3);
    tbl[8]  = mkv(1'b0, 16'h0000, 1'b1, 1'b0, 64'h0, 4'h0);
    tbl[9]  = mkv(1'b1, 16'h1111, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[10] = mkv(1'b1, 16'h2222, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[11] = mkv(1'b1, 16'h3333, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[12] = mkv(1'b1, 16'h4444, 1'b1, 1'b1, 64'h4444_3333_2222_1111, 4'hF);
    tbl[13] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[14] = mkv(1'b1, 16'h5555, 1'b1, 1'b1, 64'h0000_0000_0000_5555, 4'h1);
    tbl[15] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[16] = mkv(1'b1, 16'h6666, 1'b0, 1'b0, 64'h0, 4'h0);
    tbl[17] = mkv(1'b1, 16'h7777, 1'b1, 1'b1, 64'h0000_0000_7777_6666, 4'h3);
    tbl[18] = mkv(1'b0, 16'h0000, 1'b0, 1'b0, 64'h0, 4'h0);

    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_valid",  64'(m_valid),  64'h0);
    chk("reset m_data",   m_data,        64'h0);
    chk("reset m_mask",   64'(m_mask),   64'h0);
    chk("reset stall",    64'(stall),    64'h0);
    chk("reset overflow", 64'(overflow), 64'h0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    step();

    // Packing, flush and same-cycle flush with the consumer always ready
    for (int i = 0; i < 19; i++) begin
      res_valid = tbl[i].v;
      res_data  = tbl[i].d;
      flush     = tbl[i].f;
      step();
      chk($sformatf("vec%0d m_valid", i),  64'(m_valid),  64'(tbl[i].mv));
      chk($sformatf("vec%0d m_data", i),   m_data,        tbl[i].md);
      chk($sformatf("vec%0d m_mask", i),   64'(m_mask),   64'(tbl[i].mk));
      chk($sformatf("vec%0d stall", i),    64'(stall),    64'h0);
      chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'h0);
    end
    res_valid = 1'b0; res_data = '0; flush = 1'b0;
`ifdef PE_COLLECT_STATS_EN
    chk("word_cnt after table", 64'(word_cnt), 64'd5);
`endif

    // Fill the FIFO with the consumer blocked; the ninth word is dropped
    for (int k = 0; k < 9; k++) begin
      push_word(k, 1'b0);
      chk($sformatf("fill w%0d stall", k),    64'(stall),    64'((k + 1) >= 5));
      chk($sformatf("fill w%0d overflow", k), 64'(overflow), 64'(k == 8));
      if (k == 7) begin
        chk("full m_valid", 64'(m_valid), 64'h1);
        chk("full head",    m_data,       wordk(0));
      end
    end
`ifdef PE_COLLECT_STATS_EN
    chk("drop_cnt after drop", 64'(drop_cnt), 64'd1);
`endif

    // Push into a full FIFO while the head is popped: nothing lost
    push_word(9, 1'b1);
    chk("full+pop head",  m_data,       wordk(1));
    chk("full+pop stall", 64'(stall),   64'h1);
`ifdef PE_COLLECT_STATS_EN
    chk("drop_cnt full+pop", 64'(drop_cnt), 64'd1);
`endif
    m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d m_valid", j), 64'(m_valid), 64'h1);
      chk($sformatf("drain%0d m_data", j),  m_data,       wordk((j < 7) ? j + 1 : 9));
      chk($sformatf("drain%0d m_mask", j),  64'(m_mask),  64'hF);
      step();
      chk($sformatf("drain%0d stall", j),   64'(stall),   64'((7 - j) >= 5));
    end
    chk("drained m_valid", 64'(m_valid), 64'h0);
`ifdef PE_COLLECT_STATS_EN
    chk("word_cnt after drain", 64'(word_cnt), 64'd14);
`endif

    // Asynchronous reset mid-word with words queued
    m_ready = 1'b0;
    push_word(20, 1'b0);
    push_word(21, 1'b0);
    push_word(22, 1'b0);
    res_valid = 1'b1; res_data = 16'hC0C0; step();
    res_data  = 16'hC1C1; step();
    res_valid = 1'b0; res_data = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst m_valid",  64'(m_valid),  64'h0);
    chk("async rst m_data",   m_data,        64'h0);
    chk("async rst m_mask",   64'(m_mask),   64'h0);
    chk("async rst stall",    64'(stall),    64'h0);
    chk("async rst overflow", 64'(overflow), 64'h0);
`ifdef PE_COLLECT_STATS_EN
    chk("async rst word_cnt", 64'(word_cnt), 64'h0);
    chk("async rst drop_cnt", 64'(drop_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_data  = 16'h00A0 + 16'(i);
      step();
    end
    res_valid = 1'b0; res_data = '0;
    chk("post-rst m_valid", 64'(m_valid), 64'h1);
    chk("post-rst m_data",  m_data,       64'h00A3_00A2_00A1_00A0);
    chk("post-rst m_mask",  64'(m_mask),  64'hF);
    step();
    chk("post-rst popped",  64'(m_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
